muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS CPU.
- Executes mult/multu/div/divu over multiple cycles beside the single-cycle ALU, and services mfhi/mflo/mthi/mtlo.
- Drives a stall request back to the pipeline control while an HI/LO-dependent instruction meets a busy unit.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/md_div_step.sv | 19 +
 rtl/muldiv_seq.sv | 161 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, default width.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFixup
    } md_state_e;

    function automatic logic md_op_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_op_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Pipeline <-> multiply/divide unit bundle: issue, HI/LO moves, results and stall.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             md_start;
    logic [1:0]       md_op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mf_req;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] mt_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             div_zero;

    modport master (
        output md_start, md_op, rs_data, rt_data, mf_req, mthi_we, mtlo_we, mt_data,
        input  hi, lo, busy, stall, div_zero
    );

    modport slave (
        input  md_start, md_op, rs_data, rt_data, mf_req, mthi_we, mtlo_we, mt_data,
        output hi, lo, busy, stall, div_zero
    );
endinterface

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract divisor if it fits.
module md_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    localparam int unsigned RemW = WIDTH + 1;

    logic [WIDTH+1:0] shifted;

    assign shifted = {rem_i, bit_i};
    assign q_o     = shifted >= {2'b00, divisor_i};
    assign rem_o   = RemW'(q_o ? (shifted - {2'b00, divisor_i}) : shifted);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO. Define MULDIV_FAST_MUL_EN for a
// single-cycle combinational multiplier; divide stays iterative in both builds.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave md
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    md_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign rs_neg = md_op_signed(md.md_op) & md.rs_data[WIDTH-1];
    assign rt_neg = md_op_signed(md.md_op) & md.rt_data[WIDTH-1];
    // Unsigned magnitude, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
    assign rs_mag = rs_neg ? -md.rs_data : md.rs_data;
    assign rt_mag = rt_neg ? -md.rt_data : md.rt_data;

    // Multiplier sits in acc low half and shifts out LSB-first as product bits shift in.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);

    md_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .divisor_i(opa_q),
        .bit_i    (opb_q[WIDTH-1]),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = dz_q ? '1 : (neg_res_q ? -opb_q : opb_q);
    assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            StIdle: begin
                if (md.md_start) begin
                    is_div_d  = md_op_is_div(md.md_op);
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    dz_d      = md_op_is_div(md.md_op) && (md.rt_data == '0);
                    cnt_d     = CntW'(WIDTH);
                    if (md_op_is_div(md.md_op)) begin
                        opa_d   = rt_mag;
                        opb_d   = rs_mag;
                        rem_d   = '0;
                        state_d = StDiv;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
                        state_d = StFixup;
`else
                        opa_d   = rs_mag;
                        acc_d   = {{WIDTH{1'b0}}, rt_mag};
                        state_d = StMul;
`endif
                    end
                end else begin
                    if (md.mthi_we) hi_d = md.mt_data;
                    if (md.mtlo_we) lo_d = md.mt_data;
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFixup;
            end
            StDiv: begin
                rem_d = step_rem;
                opb_d = {opb_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFixup;
            end
            StFixup: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.busy     = (state_q != StIdle);
    assign md.stall    = md.busy & (md.md_start | md.mf_req | md.mthi_we | md.mtlo_we);
    assign md.div_zero = (state_q == StFixup) & is_div_q & dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + random bench for muldiv_seq against a plain-arithmetic HI/LO reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned W      = 32;
    localparam int          DivLat = W + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int          MulLat = 1;
`else
    localparam int          MulLat = W + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) md_bus ();

    muldiv_seq #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (md_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        md_bus.md_start = 1'b0;
        md_bus.md_op    = MD_MULT;
        md_bus.rs_data  = '0;
        md_bus.rt_data  = '0;
        md_bus.mf_req   = 1'b0;
        md_bus.mthi_we  = 1'b0;
        md_bus.mtlo_we  = 1'b0;
        md_bus.mt_data  = '0;
    endtask

    // MIPS semantics: 64-bit product; quotient truncates toward zero, remainder takes dividend sign.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] e_hi,
                                      output logic [31:0] e_lo, output int e_dz);
        longint      sa, sb;
        logic [63:0] r;
        if (op == MD_MULT || op == MD_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        e_dz = 0;
        if (op == MD_MULT || op == MD_MULTU) begin
            r    = 64'(sa * sb);
            e_hi = r[63:32];
            e_lo = r[31:0];
        end else if (b == 32'd0) begin
            e_hi = a;
            e_lo = '1;
            e_dz = 1;
        end else begin
            r    = 64'(sa / sb);
            e_lo = r[31:0];
            r    = 64'(sa % sb);
            e_hi = r[31:0];
        end
    endfunction

    // Starts and ends on a negedge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit mt_with);
        logic [31:0] old_hi, old_lo, e_hi, e_lo;
        int          e_dz, lat, n, dz_cnt;
        bit          held;
        ref_model(op, a, b, e_hi, e_lo, e_dz);
        lat    = (op == MD_DIV || op == MD_DIVU) ? DivLat : MulLat;
        old_hi = md_bus.hi;
        old_lo = md_bus.lo;
        md_bus.md_start = 1'b1;
        md_bus.md_op    = op;
        md_bus.rs_data  = a;
        md_bus.rt_data  = b;
        if (mt_with) begin
            md_bus.mthi_we = 1'b1;
            md_bus.mtlo_we = 1'b1;
            md_bus.mt_data = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        n      = 0;
        held   = 1'b1;
        dz_cnt = 0;
        while (md_bus.busy === 1'b1 && n < 200) begin
            if (md_bus.hi !== old_hi || md_bus.lo !== old_lo) held = 1'b0;
            if (md_bus.div_zero === 1'b1) dz_cnt++;
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(lat));
        check({tag, " hilo_held"}, 64'(held), 64'd1);
        check({tag, " hi"}, 64'(md_bus.hi), 64'(e_hi));
        check({tag, " lo"}, 64'(md_bus.lo), 64'(e_lo));
        check({tag, " div_zero_pulses"}, 64'(dz_cnt), 64'(e_dz));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          n;
        bit          stall_ok;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(md_bus.hi), 64'd0);
        check("reset lo", 64'(md_bus.lo), 64'd0);
        check("reset busy", 64'(md_bus.busy), 64'd0);
        check("reset div_zero", 64'(md_bus.div_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max hi const", 64'(md_bus.hi), 64'hFFFF_FFFE);
        check("multu_max lo const", 64'(md_bus.lo), 64'h0000_0001);
        run_op("mult_m3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_m3x7 lo const", 64'(md_bus.lo), 64'hFFFF_FFEB);
        run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7d2 lo const", 64'(md_bus.lo), 64'hFFFF_FFFD);
        run_op("divu_100d0", MD_DIVU, 32'd100, 32'd0, 1'b0);
        check("divu_100d0 hi const", 64'(md_bus.hi), 64'h0000_0064);
        run_op("div_m5d0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf lo const", 64'(md_bus.lo), 64'h8000_0000);
        run_op("mult_minmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mult_zero", MD_MULT, 32'd0, 32'd12345, 1'b0);
        run_op("mult_6xm5", MD_MULT, 32'd6, 32'hFFFF_FFFB, 1'b0);
        check("mult_6xm5 lo const", 64'(md_bus.lo), 64'hFFFF_FFE2);
        // mt writes alongside md_start are dropped
        run_op("multu_mt_drop", MD_MULTU, 32'd2, 32'd3, 1'b1);

        md_bus.mthi_we = 1'b1;
        md_bus.mt_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        idle_inputs();
        check("mthi hi", 64'(md_bus.hi), 64'h1234);
        check("mthi lo kept", 64'(md_bus.lo), 64'd6);
        @(negedge clk);
        md_bus.mthi_we = 1'b1;
        md_bus.mtlo_we = 1'b1;
        md_bus.mt_data = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        idle_inputs();
        check("mt both hi", 64'(md_bus.hi), 64'hA5A5_0F0F);
        check("mt both lo", 64'(md_bus.lo), 64'hA5A5_0F0F);
        @(negedge clk);

        // Stall: HI/LO requests presented while busy are refused until busy drops.
        md_bus.md_start = 1'b1;
        md_bus.md_op    = MD_DIVU;
        md_bus.rs_data  = 32'd1000;
        md_bus.rt_data  = 32'd7;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (5) @(negedge clk);
        n        = 0;
        stall_ok = 1'b1;
        while (n < 200) begin
            if (md_bus.busy === 1'b1) begin
                md_bus.md_start = 1'b1;
                md_bus.md_op    = MD_MULT;
                md_bus.rs_data  = 32'd5;
                md_bus.rt_data  = 32'd5;
                md_bus.mf_req   = 1'b1;
                md_bus.mthi_we  = 1'b1;
                md_bus.mt_data  = 32'h5555_5555;
                #1;
                if (md_bus.stall !== 1'b1) stall_ok = 1'b0;
                n++;
                @(negedge clk);
            end else begin
                idle_inputs();
                md_bus.mf_req = 1'b1;
                #1;
                check("stall low after busy", 64'(md_bus.stall), 64'd0);
                md_bus.mf_req = 1'b0;
                break;
            end
        end
        check("stall high while busy", 64'(stall_ok), 64'd1);
        check("stall cycles", 64'(n), 64'(DivLat - 4));
        check("stall op hi", 64'(md_bus.hi), 64'd6);
        check("stall op lo", 64'(md_bus.lo), 64'd142);
        @(negedge clk);

        // Asynchronous reset mid-divide discards the result.
        md_bus.md_start = 1'b1;
        md_bus.md_op    = MD_DIV;
        md_bus.rs_data  = 32'h7FFF_FFFF;
        md_bus.rt_data  = 32'd3;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(md_bus.busy), 64'd0);
        check("midreset hi", 64'(md_bus.hi), 64'd0);
        check("midreset lo", 64'(md_bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("divu_9d4", MD_DIVU, 32'd9, 32'd4, 1'b0);
        check("divu_9d4 lo const", 64'(md_bus.lo), 64'd2);
        check("divu_9d4 hi const", 64'(md_bus.hi), 64'd1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
